// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI constants, request record, bridge FSM states and beat-size helper.
package axi_pkg;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef struct packed {
        logic        we;
        logic [63:0] addr;
        logic [7:0]  len;
    } axi_req_t;

    typedef enum logic [2:0] {ST_IDLE, ST_AR, ST_R, ST_AW, ST_W, ST_B} bridge_state_e;

    function automatic logic [2:0] axi_size(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first request at or after ptr_i; returns one-hot grant,
// its index and the pointer value that follows it.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o,
    output logic [PW-1:0] next_ptr_o
);
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any_o && req_i[(int'(ptr_i) + k) % N]) begin
                any_o = 1'b1;
                idx_o = PW'((int'(ptr_i) + k) % N);
                grant_o[(int'(ptr_i) + k) % N] = 1'b1;
            end
        end
        next_ptr_o = (int'(idx_o) == N - 1) ? '0 : idx_o + PW'(1);
    end
endmodule

// File: rtl/axi_cache_bridge.sv
// axi_cache_bridge: N cache ports to one AXI4 master, round-robin, one transaction in flight.
// Define AXI_BRIDGE_PERF_EN to add per-port completed read/write burst counters.
module axi_cache_bridge
    import axi_pkg::*;
#(
    parameter int              N_PORT  = 2,
    parameter int              ADDR_W  = 32,
    parameter int              DATA_W  = 32,
    parameter int              ID_W    = 4,
    parameter logic [N_PORT-1:0] WR_MASK = 2'b10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_PORT-1:0]        req_valid_i,
    output logic [N_PORT-1:0]        req_ready_o,
    input  logic [N_PORT-1:0]        req_we_i,
    input  logic [N_PORT*ADDR_W-1:0] req_addr_i,
    input  logic [N_PORT*8-1:0]      req_len_i,
    input  logic [N_PORT*DATA_W-1:0] wdata_i,
    input  logic [N_PORT*DATA_W/8-1:0] wstrb_i,
    input  logic [N_PORT-1:0]        wvalid_i,
    output logic [N_PORT-1:0]        wready_o,
    output logic [N_PORT-1:0]        rvalid_o,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     rlast_o,
    output logic                     rerr_o,
    output logic [N_PORT-1:0]        bvalid_o,
    output logic                     berr_o,
    output logic [ID_W-1:0]          m_arid,
    output logic [ADDR_W-1:0]        m_araddr,
    output logic [7:0]               m_arlen,
    output logic [2:0]               m_arsize,
    output logic [1:0]               m_arburst,
    output logic [1:0]               m_arlock,
    output logic [3:0]               m_arcache,
    output logic [2:0]               m_arprot,
    output logic [3:0]               m_arqos,
    output logic [3:0]               m_arregion,
    output logic                     m_arvalid,
    input  logic                     m_arready,
    input  logic [ID_W-1:0]          m_rid,
    input  logic [DATA_W-1:0]        m_rdata,
    input  logic [1:0]               m_rresp,
    input  logic                     m_rlast,
    input  logic                     m_rvalid,
    output logic                     m_rready,
    output logic [ID_W-1:0]          m_awid,
    output logic [ADDR_W-1:0]        m_awaddr,
    output logic [7:0]               m_awlen,
    output logic [2:0]               m_awsize,
    output logic [1:0]               m_awburst,
    output logic [1:0]               m_awlock,
    output logic [3:0]               m_awcache,
    output logic [2:0]               m_awprot,
    output logic [3:0]               m_awqos,
    output logic [3:0]               m_awregion,
    output logic                     m_awvalid,
    input  logic                     m_awready,
    output logic [ID_W-1:0]          m_wid,
    output logic [DATA_W-1:0]        m_wdata,
    output logic [DATA_W/8-1:0]      m_wstrb,
    output logic                     m_wlast,
    output logic                     m_wvalid,
    input  logic                     m_wready,
    input  logic [ID_W-1:0]          m_bid,
    input  logic [1:0]               m_bresp,
    input  logic                     m_bvalid,
    output logic                     m_bready
`ifdef AXI_BRIDGE_PERF_EN
    ,
    output logic [N_PORT*32-1:0]     perf_rd_cnt_o,
    output logic [N_PORT*32-1:0]     perf_wr_cnt_o
`endif
);
    localparam int PW = (N_PORT > 1) ? $clog2(N_PORT) : 1;
    localparam int SW = DATA_W / 8;

    bridge_state_e       state_q, state_d;
    axi_req_t            req_q, req_d;
    logic [PW-1:0]       g_q, g_d, rr_q, rr_d, arb_idx, arb_next;
    logic [N_PORT-1:0]   elig, arb_gnt, g_oh;
    logic                arb_any;
    logic [7:0]          cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [N_PORT-1:0]   rvalid_q, rvalid_d, bvalid_q, bvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rlast_q, rlast_d, rerr_q, rerr_d, berr_q, berr_d;
    logic                r_beat, w_beat, b_hs;
    logic                unused_ok;

    // Ports without write permission are masked out here so a stray write cannot stall arbitration.
    assign elig = req_valid_i & ~(req_we_i & ~WR_MASK);

    rr_arbiter #(.N(N_PORT), .PW(PW)) u_arb (
        .req_i      (elig),
        .ptr_i      (rr_q),
        .grant_o    (arb_gnt),
        .idx_o      (arb_idx),
        .any_o      (arb_any),
        .next_ptr_o (arb_next)
    );

    assign g_oh   = N_PORT'(1) << g_q;
    assign r_beat = (state_q == ST_R) && m_rvalid;
    assign w_beat = (state_q == ST_W) && m_wvalid && m_wready;
    assign b_hs   = (state_q == ST_B) && m_bvalid;

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        g_d      = g_q;
        rr_d     = rr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        rvalid_d = r_beat ? g_oh : '0;
        rdata_d  = r_beat ? m_rdata : rdata_q;
        rlast_d  = r_beat && m_rlast;
        rerr_d   = r_beat && m_rlast && (err_q || (m_rresp != AXI_RESP_OKAY));
        bvalid_d = b_hs ? g_oh : '0;
        berr_d   = b_hs && (m_bresp != AXI_RESP_OKAY);
        case (state_q)
            ST_IDLE: if (arb_any) begin
                g_d     = arb_idx;
                rr_d    = arb_next;
                req_d   = '{we: req_we_i[arb_idx], addr: 64'(req_addr_i[arb_idx*ADDR_W +: ADDR_W]),
                            len: req_len_i[arb_idx*8 +: 8]};
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = req_we_i[arb_idx] ? ST_AW : ST_AR;
            end
            ST_AR: state_d = m_arready ? ST_R : ST_AR;
            ST_R: if (r_beat) begin
                err_d   = err_q || (m_rresp != AXI_RESP_OKAY);
                state_d = m_rlast ? ST_IDLE : ST_R;
            end
            ST_AW: state_d = m_awready ? ST_W : ST_AW;
            ST_W: if (w_beat) begin
                cnt_d   = cnt_q + 8'd1;
                state_d = m_wlast ? ST_B : ST_W;
            end
            ST_B: state_d = m_bvalid ? ST_IDLE : ST_B;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            req_q    <= '0;
            g_q      <= '0;
            rr_q     <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            rlast_q  <= 1'b0;
            rerr_q   <= 1'b0;
            bvalid_q <= '0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            g_q      <= g_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rlast_q  <= rlast_d;
            rerr_q   <= rerr_d;
            bvalid_q <= bvalid_d;
            berr_q   <= berr_d;
        end
    end

    // Gated by rst_n so no requester sees a grant while the bridge is held in reset.
    assign req_ready_o = (state_q == ST_IDLE && rst_n) ? arb_gnt : '0;
    assign wready_o    = (state_q == ST_W && m_wready) ? g_oh : '0;
    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;
    assign rlast_o     = rlast_q;
    assign rerr_o      = rerr_q;
    assign bvalid_o    = bvalid_q;
    assign berr_o      = berr_q;

    assign m_arvalid  = state_q == ST_AR;
    assign m_arid     = ID_W'(g_q);
    assign m_araddr   = req_q.addr[ADDR_W-1:0];
    assign m_arlen    = req_q.len;
    assign m_arsize   = axi_size(DATA_W);
    assign m_arburst  = AXI_BURST_INCR;
    assign m_arlock   = '0;
    assign m_arcache  = '0;
    assign m_arprot   = '0;
    assign m_arqos    = '0;
    assign m_arregion = '0;
    assign m_rready   = state_q == ST_R;

    assign m_awvalid  = state_q == ST_AW;
    assign m_awid     = ID_W'(g_q);
    assign m_awaddr   = req_q.addr[ADDR_W-1:0];
    assign m_awlen    = req_q.len;
    assign m_awsize   = axi_size(DATA_W);
    assign m_awburst  = AXI_BURST_INCR;
    assign m_awlock   = '0;
    assign m_awcache  = '0;
    assign m_awprot   = '0;
    assign m_awqos    = '0;
    assign m_awregion = '0;

    assign m_wvalid   = (state_q == ST_W) && wvalid_i[g_q];
    assign m_wid      = ID_W'(g_q);
    assign m_wdata    = wdata_i[g_q*DATA_W +: DATA_W];
    assign m_wstrb    = wstrb_i[g_q*SW +: SW];
    assign m_wlast    = cnt_q == req_q.len;
    assign m_bready   = state_q == ST_B;

    // Responses carry no routing information we need: only one transaction is ever outstanding.
    assign unused_ok = ^{m_rid, m_bid, req_q.addr, req_q.we};

`ifdef AXI_BRIDGE_PERF_EN
    logic [N_PORT-1:0][31:0] perf_rd_q, perf_rd_d, perf_wr_q, perf_wr_d;

    always_comb begin
        perf_rd_d = perf_rd_q;
        perf_wr_d = perf_wr_q;
        if (r_beat && m_rlast) perf_rd_d[g_q] = perf_rd_q[g_q] + 32'd1;
        if (b_hs) perf_wr_d[g_q] = perf_wr_q[g_q] + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_rd_q <= '0;
            perf_wr_q <= '0;
        end else begin
            perf_rd_q <= perf_rd_d;
            perf_wr_q <= perf_wr_d;
        end
    end

    assign perf_rd_cnt_o = perf_rd_q;
    assign perf_wr_cnt_o = perf_wr_q;
`endif

    always @(posedge clk) begin
        if (rst_n && state_q == ST_IDLE)
            assert (!(|(req_valid_i & req_we_i & ~WR_MASK)))
            else $warning("write request from port without write permission: %b", req_valid_i & req_we_i & ~WR_MASK);
    end
endmodule

// File: tb/tb_axi_cache_bridge.sv
// tb_axi_cache_bridge: directed checks of arbitration, read/write bursts, error reporting and reset.
module tb_axi_cache_bridge;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid_i, req_ready_o, req_we_i;
    logic [63:0] req_addr_i;
    logic [15:0] req_len_i;
    logic [63:0] wdata_i;
    logic [7:0]  wstrb_i;
    logic [1:0]  wvalid_i, wready_o, rvalid_o, bvalid_o;
    logic [31:0] rdata_o;
    logic        rlast_o, rerr_o, berr_o;
    logic [3:0]  m_arid, m_awid, m_wid, m_rid, m_bid;
    logic [31:0] m_araddr, m_awaddr, m_rdata, m_wdata;
    logic [7:0]  m_arlen, m_awlen;
    logic [2:0]  m_arsize, m_awsize, m_arprot, m_awprot;
    logic [1:0]  m_arburst, m_awburst, m_arlock, m_awlock, m_rresp, m_bresp;
    logic [3:0]  m_arcache, m_awcache, m_arqos, m_awqos, m_arregion, m_awregion, m_wstrb;
    logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
    logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
`ifdef AXI_BRIDGE_PERF_EN
    logic [63:0] perf_rd_cnt_o, perf_wr_cnt_o;
`endif
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    axi_cache_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_len_i(req_len_i),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .rlast_o(rlast_o), .rerr_o(rerr_o),
        .bvalid_o(bvalid_o), .berr_o(berr_o),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
        .m_arqos(m_arqos), .m_arregion(m_arregion), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
        .m_awqos(m_awqos), .m_awregion(m_awregion), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
`ifdef AXI_BRIDGE_PERF_EN
        , .perf_rd_cnt_o(perf_rd_cnt_o), .perf_wr_cnt_o(perf_wr_cnt_o)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller has driven the request; bridge is idle. Serves a read burst as the AXI slave.
    task automatic rd_txn(input int p, input logic [31:0] addr, input logic [7:0] len,
                          input int err_beat, input logic [1:0] drop);
        #1;
        chk("rd_grant", 64'(req_ready_o), 64'(2'b01 << p));
        tick();
        req_valid_i &= ~drop;
        chk("arvalid", 64'(m_arvalid), 64'd1);
        chk("arid", 64'(m_arid), 64'(p));
        chk("araddr", 64'(m_araddr), 64'(addr));
        chk("arlen", 64'(m_arlen), 64'(len));
        chk("arsize", 64'(m_arsize), 64'd2);
        chk("arburst", 64'(m_arburst), 64'd1);
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        chk("rready", 64'(m_rready), 64'd1);
        chk("arvalid_drop", 64'(m_arvalid), 64'd0);
        for (int b = 0; b <= int'(len); b++) begin
            m_rvalid = 1'b1;
            m_rdata  = 32'hD000_0000 + 32'(b) + 32'(p << 8);
            m_rlast  = (b == int'(len));
            m_rresp  = (b == err_beat) ? 2'b10 : 2'b00;
            tick();
            chk("rvalid_o", 64'(rvalid_o), 64'(2'b01 << p));
            chk("rdata_o", 64'(rdata_o), 64'(32'hD000_0000 + 32'(b) + 32'(p << 8)));
            chk("rlast_o", 64'(rlast_o), 64'(b == int'(len)));
            chk("rerr_o", 64'(rerr_o), 64'((b == int'(len)) && err_beat >= 0 && err_beat <= int'(len)));
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        m_rresp  = 2'b00;
        chk("rready_idle", 64'(m_rready), 64'd0);
    endtask

    task automatic wr_txn(input int p, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] bresp, input logic [1:0] drop);
        #1;
        chk("wr_grant", 64'(req_ready_o), 64'(2'b01 << p));
        tick();
        req_valid_i &= ~drop;
        chk("awvalid", 64'(m_awvalid), 64'd1);
        chk("awid", 64'(m_awid), 64'(p));
        chk("awaddr", 64'(m_awaddr), 64'(addr));
        chk("awlen", 64'(m_awlen), 64'(len));
        m_awready = 1'b1;
        tick();
        m_awready = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wvalid_i[p] = 1'b1;
            wdata_i[p*32 +: 32] = b[0] ? 32'h5A5A_5A5A : 32'hA5A5_A5A5;
            wstrb_i[p*4 +: 4] = 4'hF;
            m_wready = 1'b1;
            #1;
            chk("wvalid", 64'(m_wvalid), 64'd1);
            chk("wdata", 64'(m_wdata), 64'(b[0] ? 32'h5A5A_5A5A : 32'hA5A5_A5A5));
            chk("wstrb", 64'(m_wstrb), 64'hF);
            chk("wlast", 64'(m_wlast), 64'(b == int'(len)));
            chk("wready_o", 64'(wready_o), 64'(2'b01 << p));
            chk("wid", 64'(m_wid), 64'(p));
            tick();
        end
        wvalid_i = '0;
        m_wready = 1'b0;
        chk("bready", 64'(m_bready), 64'd1);
        m_bvalid = 1'b1;
        m_bresp  = bresp;
        tick();
        m_bvalid = 1'b0;
        m_bresp  = 2'b00;
        chk("bvalid_o", 64'(bvalid_o), 64'(2'b01 << p));
        chk("berr_o", 64'(berr_o), 64'(bresp != 2'b00));
        tick();
        chk("bvalid_once", 64'(bvalid_o), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid_i = '0; req_we_i = '0; req_addr_i = '0; req_len_i = '0;
        wdata_i = '0; wstrb_i = '0; wvalid_i = '0;
        m_arready = 0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 0; m_rvalid = 0;
        m_awready = 0; m_wready = 0; m_bid = '0; m_bresp = '0; m_bvalid = 0;
        repeat (2) tick();
        req_valid_i = 2'b01;
        #1;
        chk("rst_req_ready", 64'(req_ready_o), 64'd0);
        chk("rst_rvalid", 64'(rvalid_o), 64'd0);
        chk("rst_rdata", 64'(rdata_o), 64'd0);
        chk("rst_axi_valid", 64'({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}), 64'd0);
        req_valid_i = '0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("const_fields", 64'({m_arlock, m_arcache, m_arprot, m_awlock, m_awcache, m_awprot}), 64'd0);

        req_valid_i = 2'b01; req_we_i = 2'b00;
        req_addr_i[31:0] = 32'h1C00_0000; req_len_i[7:0] = 8'd3;
        rd_txn(0, 32'h1C00_0000, 8'd3, -1, 2'b01);

        req_valid_i = 2'b10; req_we_i = 2'b10;
        req_addr_i[63:32] = 32'h0000_1000; req_len_i[15:8] = 8'd1;
        wr_txn(1, 32'h0000_1000, 8'd1, 2'b00, 2'b10);
        chk("awsize", 64'(m_awsize), 64'd2);

        req_valid_i = 2'b11; req_we_i = 2'b00;
        req_addr_i = {32'h0000_0200, 32'h0000_0100}; req_len_i = {8'd1, 8'd0};
        for (int i = 0; i < 4; i++)
            rd_txn(i % 2, (i % 2) ? 32'h200 : 32'h100, (i % 2) ? 8'd1 : 8'd0, -1,
                   (i == 3) ? 2'b11 : 2'b00);

        req_valid_i = 2'b01; req_we_i = 2'b00;
        req_addr_i[31:0] = 32'h0000_0400; req_len_i[7:0] = 8'd3;
        rd_txn(0, 32'h400, 8'd3, 1, 2'b01);

        req_valid_i = 2'b10; req_we_i = 2'b10;
        req_addr_i[63:32] = 32'h0000_2000; req_len_i[15:8] = 8'd0;
        wr_txn(1, 32'h2000, 8'd0, 2'b11, 2'b10);

        req_valid_i = 2'b11; req_we_i = 2'b11;
        req_addr_i = {32'h0000_3000, 32'h0000_3100}; req_len_i = {8'd0, 8'd0};
        wr_txn(1, 32'h3000, 8'd0, 2'b00, 2'b10);
        for (int i = 0; i < 2; i++) begin
            chk("illegal_no_grant", 64'(req_ready_o), 64'd0);
            chk("illegal_no_aw", 64'({m_awvalid, m_arvalid}), 64'd0);
            tick();
        end
        req_valid_i = '0; req_we_i = '0;
`ifdef AXI_BRIDGE_PERF_EN
        chk("perf_rd", perf_rd_cnt_o, {32'd2, 32'd4});
        chk("perf_wr", perf_wr_cnt_o, {32'd3, 32'd0});
`endif

        req_valid_i = 2'b01;
        req_addr_i[31:0] = 32'h0000_5000; req_len_i[7:0] = 8'd3;
        #1;
        chk("mid_grant", 64'(req_ready_o), 64'd1);
        tick();
        req_valid_i = '0;
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'h1234_5678;
        tick();
        m_rvalid = 1'b0;
        chk("mid_beat", 64'(rvalid_o), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", 64'(rvalid_o), 64'd0);
        chk("mid_rst_rdata", 64'(rdata_o), 64'd0);
        chk("mid_rst_rready", 64'(m_rready), 64'd0);
`ifdef AXI_BRIDGE_PERF_EN
        chk("mid_rst_perf", {perf_rd_cnt_o[31:0], perf_wr_cnt_o[63:32]}, 64'd0);
`endif
        tick();
        rst_n = 1'b1;
        req_valid_i = 2'b11; req_we_i = 2'b00;
        #1;
        chk("rr_ptr_reset", 64'(req_ready_o), 64'd1);
        req_valid_i = '0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
